// File: rtl/pipe_reg_skid.sv
// ============================================================================
// Module   : pipe_reg_skid
// Brief    : Registered valid/ready pipeline stage with a one-entry skid
//            buffer and a true/complement data output pair.
//            Optional synchronous flush: PIPE_REG_SKID_FLUSH_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_reg_skid #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] out_data,
  output logic [n-1:0] out_data_n
`ifdef PIPE_REG_SKID_FLUSH_EN
  ,
  input  logic         flush
`endif
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [1:0]   r_state;
  logic [n-1:0] r_main;
  logic [n-1:0] r_skid;
  logic [n-1:0] r_out_data_n;
  logic         r_in_ready;
  logic         r_out_valid;

  logic [1:0]   w_state_nxt;
  logic [n-1:0] w_main_nxt;
  logic [n-1:0] w_skid_nxt;
  logic [n-1:0] w_out_data_n_nxt;
  logic         w_in_ready_nxt;
  logic         w_out_valid_nxt;
  logic         w_in_fire;
  logic         w_out_fire;
  logic         w_flush;

`ifdef PIPE_REG_SKID_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  // State register: every output is a flop, so no ready path is combinational.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_EMPTY;
      r_main       <= '0;
      r_skid       <= '0;
      r_out_data_n <= '1;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_main       <= w_main_nxt;
      r_skid       <= w_skid_nxt;
      r_out_data_n <= w_out_data_n_nxt;
      r_in_ready   <= w_in_ready_nxt;
      r_out_valid  <= w_out_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    case (r_state)
      S_EMPTY: begin
        if (w_in_fire) begin
          w_state_nxt = S_BUSY;
          w_main_nxt  = in_data;
        end
      end
      S_BUSY: begin
        if (w_in_fire && w_out_fire) begin
          w_main_nxt = in_data;
        end else if (w_in_fire) begin
          w_state_nxt = S_FULL;
          w_skid_nxt  = in_data;
        end else if (w_out_fire) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_FULL: begin
        if (w_out_fire) begin
          w_state_nxt = S_BUSY;
          w_main_nxt  = r_skid;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
    // Flush wins over any transfer in the same cycle.
    if (w_flush) begin
      w_state_nxt = S_EMPTY;
      w_main_nxt  = '0;
      w_skid_nxt  = '0;
    end
  end

  always_comb begin
    w_in_ready_nxt   = (w_state_nxt != S_FULL);
    w_out_valid_nxt  = (w_state_nxt != S_EMPTY);
    w_out_data_n_nxt = ~w_main_nxt;
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_main;
  assign out_data_n = r_out_data_n;

endmodule

`default_nettype wire

// File: tb/tb_pipe_reg_skid.sv
// ============================================================================
// Module   : tb_pipe_reg_skid
// Brief    : Directed and random check of pipe_reg_skid against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_reg_skid;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [31:0] out_data_n;
  logic        flush_s = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [31:0] q[$];
  logic [31:0] m_main  = '0;
  logic        m_ready = 1'b0;

  pipe_reg_skid #(.n(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_data_n (out_data_n)
`ifdef PIPE_REG_SKID_FLUSH_EN
    ,
    .flush      (flush_s)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out_valid"},  {31'd0, out_valid}, {31'd0, (q.size() > 0)});
    chk({tag, ".in_ready"},   {31'd0, in_ready},  {31'd0, m_ready});
    chk({tag, ".out_data"},   out_data,   m_main);
    chk({tag, ".out_data_n"}, out_data_n, ~m_main);
  endtask

  task automatic model_reset();
    q.delete();
    m_main  = '0;
    m_ready = 1'b0;
  endtask

  // One clock: drive, let the edge happen, advance the queue model, check.
  task automatic step(input string tag, input logic v, input logic [31:0] d,
                      input logic r, input logic f);
    logic ifire, ofire;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush_s   = f;
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      ifire = v && m_ready;
      ofire = (q.size() > 0) && r;
      if (f) begin
        q.delete();
        m_main = '0;
      end else begin
        if (ofire) void'(q.pop_front());
        if (ifire) q.push_back(d);
        if (q.size() > 0) m_main = q[0];
      end
      m_ready = (q.size() < 2);
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    // Reset held with in_valid asserted
    rst = 1'b0;
    step("rst0", 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    step("rst1", 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    chk("rst.out_data_n", out_data_n, 32'hFFFF_FFFF);
    chk("rst.in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    step("rel", 1'b0, 32'h0, 1'b1, 1'b0);
    chk("rel.in_ready", {31'd0, in_ready}, 32'd1);

    // Single pass
    step("sp0", 1'b1, 32'h0000_0001, 1'b1, 1'b0);
    chk("sp.data", out_data, 32'h0000_0001);
    chk("sp.data_n", out_data_n, 32'hFFFF_FFFE);
    step("sp1", 1'b0, 32'h0, 1'b1, 1'b0);
    chk("sp.valid_drop", {31'd0, out_valid}, 32'd0);

    // Backpressure
    step("bp0", 1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0);
    step("bp1", 1'b1, 32'h5A5A_5A5A, 1'b0, 1'b0);
    chk("bp.full_ready", {31'd0, in_ready}, 32'd0);
    step("bp2", 1'b1, 32'h1234_5678, 1'b0, 1'b0);
    chk("bp.hold", out_data, 32'hA5A5_A5A5);
    step("bp3", 1'b0, 32'h0, 1'b1, 1'b0);
    chk("bp.second", out_data, 32'h5A5A_5A5A);
    step("bp4", 1'b0, 32'h0, 1'b1, 1'b0);

    // Streaming 1..8
    for (int i = 1; i <= 8; i++) begin
      step("strm", 1'b1, i, 1'b1, 1'b0);
      chk("strm.word", out_data, i);
    end
    step("strm_end", 1'b0, 32'h0, 1'b1, 1'b0);

    // Mid-operation reset from FULL
    step("mr0", 1'b1, 32'h1, 1'b0, 1'b0);
    step("mr1", 1'b1, 32'h2, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("mr.async_valid", {31'd0, out_valid}, 32'd0);
    check_all("mr.async");
    step("mr2", 1'b1, 32'h9, 1'b1, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) step("mr_drain", 1'b0, 32'h0, 1'b1, 1'b0);

`ifdef PIPE_REG_SKID_FLUSH_EN
    step("fl0", 1'b1, 32'h1, 1'b0, 1'b0);
    step("fl1", 1'b1, 32'h2, 1'b0, 1'b0);
    step("fl2", 1'b1, 32'h3, 1'b1, 1'b1);
    chk("fl.valid", {31'd0, out_valid}, 32'd0);
    chk("fl.ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) step("fl_drain", 1'b0, 32'h0, 1'b1, 1'b0);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step("rnd", 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0),
`ifdef PIPE_REG_SKID_FLUSH_EN
           1'($urandom_range(0, 31) == 0)
`else
           1'b0
`endif
          );
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
